// File: rtl/vlsu_defs.sv
// Shared constants and state encoding for the vector load/store address generator.
package vlsu_defs;

  localparam int DATAMEM_BITS  = 14;
  localparam int DATAMEM_WIDTH = 32;
  localparam int LANES         = 4;
  localparam int MAX_VL        = 64;
  localparam int VL_BITS       = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STORE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/v_lsu_agen_if.sv
// Request, store-beat, bank-memory and load-beat signals of the vector LSU address generator.
interface v_lsu_agen_if #(
  parameter int DATAMEM_BITS = vlsu_defs::DATAMEM_BITS,
  parameter int VL_BITS      = vlsu_defs::VL_BITS
);

  localparam int LN = vlsu_defs::LANES;
  localparam int DW = vlsu_defs::DATAMEM_WIDTH;

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_store;
  logic [DATAMEM_BITS-1:0]     req_base;
  logic [VL_BITS-1:0]          req_vl;
  logic                        st_valid;
  logic                        st_ready;
  logic [LN-1:0][DW-1:0]       st_data;
  logic [DATAMEM_BITS-1:0]     dm_addr;
  logic [LN-1:0][3:0]          dm_write;
  logic [LN-1:0][DW-1:0]       dm_data;
  logic [LN-1:0][DW-1:0]       dm_rdata;
  logic                        ld_valid;
  logic [LN-1:0][DW-1:0]       ld_data;
  logic [LN-1:0]               ld_mask;
  logic                        ld_last;
  logic                        done;
  logic                        err;

  modport master (
    output req_valid, req_store, req_base, req_vl, st_valid, st_data, dm_rdata,
    input  req_ready, st_ready, dm_addr, dm_write, dm_data,
           ld_valid, ld_data, ld_mask, ld_last, done, err
  );

  modport slave (
    input  req_valid, req_store, req_base, req_vl, st_valid, st_data, dm_rdata,
    output req_ready, st_ready, dm_addr, dm_write, dm_data,
           ld_valid, ld_data, ld_mask, ld_last, done, err
  );

endinterface

// File: rtl/v_lsu_tailmask.sv
// Per-beat lane mask and consumed element count from the remaining element count.
module v_lsu_tailmask
  import vlsu_defs::*;
#(
  parameter int VL_BITS = vlsu_defs::VL_BITS
) (
  input  logic [VL_BITS-1:0] i_rem,
  output logic [LANES-1:0]   o_mask,
  output logic [VL_BITS-1:0] o_used
);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    o_mask = '0;
    o_used = (i_rem >= VL_BITS'(LANES)) ? VL_BITS'(LANES) : i_rem;
    for (int i = 0; i < LANES; i++) begin
      o_mask[i] = (VL_BITS'(i) < i_rem);
    end
  end

endmodule

// File: rtl/v_lsu_agen.sv
// Vector unit-stride load/store address generator and four-bank sequencer.
module v_lsu_agen
  import vlsu_defs::*;
#(
  parameter int DATAMEM_BITS = vlsu_defs::DATAMEM_BITS,
  parameter int MAX_VL       = vlsu_defs::MAX_VL,
  parameter int VL_BITS      = vlsu_defs::VL_BITS
) (
  input  logic         core_clk,
  input  logic         rst,
  v_lsu_agen_if.slave  bus
);

  state_e                    r_state, w_next;
  logic [DATAMEM_BITS-1:0]   r_addr;
  logic [VL_BITS-1:0]        r_rem;
  logic                      r_err;
  logic                      r_tag_valid;
  logic [LANES-1:0]          r_tag_mask;
  logic                      r_tag_last;

  logic [LANES-1:0]          w_mask;
  logic [VL_BITS-1:0]        w_used;
  logic                      w_last_beat;
  logic [VL_BITS:0]          w_beats;
  logic [DATAMEM_BITS-2:0]   w_row_sum;
  logic                      w_reject;

  v_lsu_tailmask #(.VL_BITS(VL_BITS)) u_tailmask (
    .i_rem  (r_rem),
    .o_mask (w_mask),
    .o_used (w_used)
  );

  assign w_last_beat = (r_rem <= VL_BITS'(LANES));
  assign w_beats     = ({1'b0, bus.req_vl} + (VL_BITS+1)'(3)) >> 2;
  assign w_row_sum   = (DATAMEM_BITS-1)'(bus.req_base[DATAMEM_BITS-2:2])
                     + (DATAMEM_BITS-1)'(w_beats) - (DATAMEM_BITS-1)'(1);

  // A carry above the row field means the last row lands in the protocol region.
  assign w_reject = (bus.req_base[1:0] != 2'b00)
                  | bus.req_base[DATAMEM_BITS-1]
                  | ((bus.req_vl != '0) && (w_row_sum[DATAMEM_BITS-2:DATAMEM_BITS-3] != 2'b00))
                  | (bus.req_vl > VL_BITS'(MAX_VL));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.st_ready  = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_write  = '0;
    bus.dm_data   = '0;
    bus.done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid && !w_reject) begin
          if (bus.req_vl == '0)  w_next = ST_FIN;
          else if (bus.req_store) w_next = ST_STORE;
          else                    w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bus.dm_addr = r_addr;
        if (w_last_beat) w_next = ST_DRAIN;
      end
      ST_STORE: begin
        bus.st_ready = 1'b1;
        bus.dm_addr  = r_addr;
        bus.dm_data  = bus.st_data;
        for (int i = 0; i < LANES; i++) begin
          bus.dm_write[i] = {4{bus.st_valid & w_mask[i]}};
        end
        if (bus.st_valid && w_last_beat) w_next = ST_FIN;
      end
      ST_DRAIN: w_next = ST_FIN;
      ST_FIN: begin
        bus.done = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_rem       <= '0;
      r_err       <= 1'b0;
      r_tag_valid <= 1'b0;
      r_tag_mask  <= '0;
      r_tag_last  <= 1'b0;
    end else begin
      r_err       <= (r_state == ST_IDLE) && bus.req_valid && w_reject;
      r_tag_valid <= (r_state == ST_LOAD);
      r_tag_mask  <= (r_state == ST_LOAD) ? w_mask : '0;
      r_tag_last  <= (r_state == ST_LOAD) && w_last_beat;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_addr <= bus.req_base;
            r_rem  <= bus.req_vl;
          end
        end
        ST_LOAD: begin
          r_addr <= r_addr + DATAMEM_BITS'(4);
          r_rem  <= r_rem - w_used;
        end
        ST_STORE: begin
          if (bus.st_valid) begin
            r_addr <= r_addr + DATAMEM_BITS'(4);
            r_rem  <= r_rem - w_used;
          end
        end
        default: ;
      endcase
    end
  end

  // The tag trails the address by one cycle, matching the banks' registered read port.
  always_comb begin
    bus.ld_valid = r_tag_valid;
    bus.ld_mask  = r_tag_mask;
    bus.ld_last  = r_tag_last;
    bus.ld_data  = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.ld_data[i] = r_tag_mask[i] ? bus.dm_rdata[i] : '0;
    end
  end

  assign bus.err = r_err;

endmodule

// File: tb/tb_v_lsu_agen.sv
// Directed self-checking bench for v_lsu_agen with a four-bank registered-read memory model.
module tb_v_lsu_agen;
  import vlsu_defs::*;

  typedef struct {
    logic [13:0] base;
    logic [6:0]  vl;
  } bad_req_t;

  logic core_clk = 1'b0;
  logic rst;
  always #5 core_clk = ~core_clk;

  v_lsu_agen_if bus ();
  v_lsu_agen dut (.core_clk(core_clk), .rst(rst), .bus(bus));

  logic [31:0] mem [LANES][4096];
  int n_checks = 0;
  int n_fail   = 0;
  int wr_events = 0;
  int ld_events = 0;
  int wr_snap, ld_snap;
  bad_req_t bad [3];

  function automatic logic [31:0] pat(input int bank, input int row);
    return 32'(32'h1000 * row + bank);
  endfunction

  // Memory model: preloaded pattern under reset, byte strobes, read data one cycle after address.
  always @(posedge core_clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (rst) begin
        for (int r = 0; r < 4096; r++) mem[i][r] <= pat(i, r);
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus.dm_write[i][b])
            mem[i][bus.dm_addr[13:2]][8*b +: 8] <= bus.dm_data[i][8*b +: 8];
        end
      end
      bus.dm_rdata[i] <= mem[i][bus.dm_addr[13:2]];
    end
  end

  always @(negedge core_clk) begin
    if (|bus.dm_write) wr_events <= wr_events + 1;
    if (bus.ld_valid)  ld_events <= ld_events + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic offer(input logic store, input logic [13:0] base, input logic [6:0] vl);
    bus.req_valid = 1'b1;
    bus.req_store = store;
    bus.req_base  = base;
    bus.req_vl    = vl;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_base  = '0;
    bus.req_vl    = '0;
    bus.st_valid  = 1'b0;
    bus.st_data   = '0;
    bad[0] = '{base: 14'h0002, vl: 7'd4};
    bad[1] = '{base: 14'h2000, vl: 7'd4};
    bad[2] = '{base: 14'h1FF8, vl: 7'd12};

    repeat (3) step();
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_ld_valid", bus.ld_valid, 0);
    check("rst_dm_addr", bus.dm_addr, 0);
    rst = 1'b0;
    step();

    // Load vl=8 at 0x0040: two full beats from rows 0x10 and 0x11.
    offer(1'b0, 14'h0040, 7'd8);
    #1 check("ld8_req_ready", bus.req_ready, 1);
    step(); bus.req_valid = 1'b0;
    #1 check("ld8_addr0", bus.dm_addr, 14'h0040);
    check("ld8_no_early_valid", bus.ld_valid, 0);
    step();
    #1 check("ld8_addr1", bus.dm_addr, 14'h0044);
    check("ld8_b1_valid", bus.ld_valid, 1);
    check("ld8_b1_mask", bus.ld_mask, 4'hF);
    check("ld8_b1_last", bus.ld_last, 0);
    check("ld8_b1_d0", bus.ld_data[0], 32'h0001_0000);
    check("ld8_b1_d3", bus.ld_data[3], 32'h0001_0003);
    step();
    #1 check("ld8_b2_valid", bus.ld_valid, 1);
    check("ld8_b2_mask", bus.ld_mask, 4'hF);
    check("ld8_b2_last", bus.ld_last, 1);
    check("ld8_b2_d0", bus.ld_data[0], 32'h0001_1000);
    check("ld8_b2_d2", bus.ld_data[2], 32'h0001_1002);
    step();
    #1 check("ld8_done", bus.done, 1);
    check("ld8_fin_ready", bus.req_ready, 0);
    check("ld8_fin_no_valid", bus.ld_valid, 0);
    step();
    #1 check("ld8_idle_done", bus.done, 0);
    check("ld8_idle_ready", bus.req_ready, 1);

    // Store vl=6 at 0x0100 with a two-cycle stall between beats.
    wr_snap = wr_events;
    offer(1'b1, 14'h0100, 7'd6);
    step(); bus.req_valid = 1'b0;
    bus.st_valid = 1'b1;
    for (int i = 0; i < LANES; i++) bus.st_data[i] = 32'hA000_0000 + 32'(i);
    #1 check("st_ready", bus.st_ready, 1);
    check("st_addr0", bus.dm_addr, 14'h0100);
    check("st_wr0", bus.dm_write, 16'hFFFF);
    check("st_data0", bus.dm_data[0], 32'hA000_0000);
    step(); bus.st_valid = 1'b0;
    #1 check("st_stall1_wr", bus.dm_write, 16'h0000);
    check("st_stall1_addr", bus.dm_addr, 14'h0104);
    step();
    #1 check("st_stall2_wr", bus.dm_write, 16'h0000);
    check("st_stall2_addr", bus.dm_addr, 14'h0104);
    bus.st_valid = 1'b1;
    for (int i = 0; i < LANES; i++) bus.st_data[i] = 32'hB000_0000 + 32'(i);
    #1 check("st_wr1", bus.dm_write, 16'h00FF);
    check("st_addr1", bus.dm_addr, 14'h0104);
    step(); bus.st_valid = 1'b0;
    #1 check("st_done", bus.done, 1);
    check("st_fin_st_ready", bus.st_ready, 0);
    step();
    #1 check("st_mem_0_40", mem[0][12'h040], 32'hA000_0000);
    check("st_mem_3_40", mem[3][12'h040], 32'hA000_0003);
    check("st_mem_1_41", mem[1][12'h041], 32'hB000_0001);
    check("st_mem_2_41_kept", mem[2][12'h041], pat(2, 12'h041));
    check("st_write_cycles", 64'(wr_events - wr_snap), 2);

    // vl=0: completes without touching memory.
    wr_snap = wr_events; ld_snap = ld_events;
    offer(1'b0, 14'h0040, 7'd0);
    step(); bus.req_valid = 1'b0;
    #1 check("vl0_done", bus.done, 1);
    check("vl0_ready_low", bus.req_ready, 0);
    step();
    #1 check("vl0_ready_back", bus.req_ready, 1);
    check("vl0_no_writes", 64'(wr_events - wr_snap), 0);
    check("vl0_no_loads", 64'(ld_events - ld_snap), 0);

    // Rejected requests.
    for (int k = 0; k < 3; k++) begin
      wr_snap = wr_events; ld_snap = ld_events;
      offer(1'b0, bad[k].base, bad[k].vl);
      step(); bus.req_valid = 1'b0;
      #1 check($sformatf("bad%0d_err", k), bus.err, 1);
      check($sformatf("bad%0d_ready", k), bus.req_ready, 1);
      check($sformatf("bad%0d_addr", k), bus.dm_addr, 0);
      step();
      #1 check($sformatf("bad%0d_err_clear", k), bus.err, 0);
      check($sformatf("bad%0d_no_access", k), 64'(wr_events - wr_snap + ld_events - ld_snap), 0);
    end

    // Reset asserted during beat 3 of a vl=16 load.
    offer(1'b0, 14'h0200, 7'd16);
    step(); bus.req_valid = 1'b0;
    step();
    step();
    #1 check("rstmid_beat3_addr", bus.dm_addr, 14'h0208);
    rst = 1'b1;
    #1 check("rstmid_ld_valid", bus.ld_valid, 0);
    check("rstmid_dm_addr", bus.dm_addr, 0);
    check("rstmid_req_ready", bus.req_ready, 1);
    check("rstmid_ld_data0", bus.ld_data[0], 0);
    repeat (2) step();
    rst = 1'b0;
    ld_snap = ld_events;
    repeat (3) step();
    check("rstmid_no_ld_after", 64'(ld_events - ld_snap), 0);
    offer(1'b0, 14'h0300, 7'd4);
    step(); bus.req_valid = 1'b0;
    #1 check("post_rst_addr", bus.dm_addr, 14'h0300);
    step();
    #1 check("post_rst_last", bus.ld_last, 1);
    check("post_rst_d1", bus.ld_data[1], 32'h000C_0001);
    step();
    #1 check("post_rst_done", bus.done, 1);
    step();

    // Back-to-back: store offered while a load is in flight waits for done.
    offer(1'b0, 14'h0400, 7'd4);
    step();
    offer(1'b1, 14'h0400, 7'd4);
    bus.st_valid = 1'b1;
    for (int i = 0; i < LANES; i++) bus.st_data[i] = 32'hC0DE_0000 + 32'(i);
    #1 check("b2b_busy_ready", bus.req_ready, 0);
    check("b2b_busy_no_write", bus.dm_write, 16'h0000);
    step();
    #1 check("b2b_ld_d0", bus.ld_data[0], 32'h0010_0000);
    check("b2b_drain_ready", bus.req_ready, 0);
    step();
    #1 check("b2b_ld_done", bus.done, 1);
    check("b2b_fin_ready", bus.req_ready, 0);
    step();
    #1 check("b2b_idle_ready", bus.req_ready, 1);
    step(); bus.req_valid = 1'b0;
    #1 check("b2b_st_wr", bus.dm_write, 16'hFFFF);
    check("b2b_st_addr", bus.dm_addr, 14'h0400);
    step(); bus.st_valid = 1'b0;
    #1 check("b2b_st_done", bus.done, 1);
    step();
    offer(1'b0, 14'h0400, 7'd4);
    step(); bus.req_valid = 1'b0;
    step();
    #1 check("reload_d0", bus.ld_data[0], 32'hC0DE_0000);
    check("reload_d3", bus.ld_data[3], 32'hC0DE_0003);
    check("reload_mask", bus.ld_mask, 4'hF);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
